// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator.
//   vga_mode_e  : runtime pattern selection (bars, checker, gradient, scrolling bars)
//   CI_*        : 3-bit colour indices, bit 2 = red, bit 1 = green, bit 0 = blue
//   bar_colour  : colour index of a given colour-bar column
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_CHECK  = 2'd1,
        MODE_GRAD   = 2'd2,
        MODE_SCROLL = 2'd3
    } vga_mode_e;

    localparam logic [2:0] CI_BLACK   = 3'b000;
    localparam logic [2:0] CI_BLUE    = 3'b001;
    localparam logic [2:0] CI_GREEN   = 3'b010;
    localparam logic [2:0] CI_CYAN    = 3'b011;
    localparam logic [2:0] CI_RED     = 3'b100;
    localparam logic [2:0] CI_MAGENTA = 3'b101;
    localparam logic [2:0] CI_YELLOW  = 3'b110;
    localparam logic [2:0] CI_WHITE   = 3'b111;

    // Classic test-card order, left to right. This is not a plain 7-col
    // countdown of the RGB index, hence the explicit table.
    function automatic logic [2:0] bar_colour(input logic [2:0] col);
        logic [2:0] ci;
        case (col)
            3'd0:    ci = CI_WHITE;
            3'd1:    ci = CI_YELLOW;
            3'd2:    ci = CI_CYAN;
            3'd3:    ci = CI_GREEN;
            3'd4:    ci = CI_MAGENTA;
            3'd5:    ci = CI_RED;
            3'd6:    ci = CI_BLUE;
            default: ci = CI_BLACK;
        endcase
        return ci;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and the raw (unregistered) timing flags.
//   clk, rst_n            : pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt          : current raster position
//   active                : position is inside the visible area
//   hsync_act, vsync_act  : sync pulse interval (polarity applied downstream)
//   frame_start           : position is (0,0)
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_PIXELS       = 800,
    parameter int H_FRONTPORCH   = 40,
    parameter int H_SYNCTIME     = 128,
    parameter int H_BACKPORCH    = 88,
    parameter int V_LINES        = 600,
    parameter int V_FRONTPORCH   = 1,
    parameter int V_SYNCTIME     = 4,
    parameter int V_BACKPORCH    = 23,
    parameter int PIXEL_GEN_BITS = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [PIXEL_GEN_BITS-1:0] h_cnt,
    output logic [PIXEL_GEN_BITS-1:0] v_cnt,
    output logic                      active,
    output logic                      hsync_act,
    output logic                      vsync_act,
    output logic                      frame_start
);

    localparam int PGB = PIXEL_GEN_BITS;

    localparam logic [PGB-1:0] H_LAST = PGB'(H_PIXELS + H_FRONTPORCH + H_SYNCTIME + H_BACKPORCH - 1);
    localparam logic [PGB-1:0] V_LAST = PGB'(V_LINES + V_FRONTPORCH + V_SYNCTIME + V_BACKPORCH - 1);
    localparam logic [PGB-1:0] H_ACT  = PGB'(H_PIXELS);
    localparam logic [PGB-1:0] V_ACT  = PGB'(V_LINES);
    localparam logic [PGB-1:0] H_SS   = PGB'(H_PIXELS + H_FRONTPORCH);
    localparam logic [PGB-1:0] H_SE   = PGB'(H_PIXELS + H_FRONTPORCH + H_SYNCTIME);
    localparam logic [PGB-1:0] V_SS   = PGB'(V_LINES + V_FRONTPORCH);
    localparam logic [PGB-1:0] V_SE   = PGB'(V_LINES + V_FRONTPORCH + V_SYNCTIME);

    logic [PGB-1:0] h_cnt_q, h_cnt_d;
    logic [PGB-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + PGB'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + PGB'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // S0: flags decoded straight from the counters
    always_comb begin
        h_cnt       = h_cnt_q;
        v_cnt       = v_cnt_q;
        active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_act   = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        vsync_act   = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
        frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator.
//   clk_pll, rst         : pixel clock, asynchronous active-low reset
//   mode                 : pattern select, taken only at frame start
//   freeze               : hold the frame counter / scroll offset
//   HSYNC, VSYNC         : sync outputs with configurable polarity
//   DE                   : active video enable
//   FRAME_START          : one-clock pulse with pixel (0,0)
//   RED/GREEN/BLUE_OUT   : colour, forced to 0 outside the active area
// All outputs trail the raster counters by two clocks and are mutually aligned.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_PIXELS          = 800,
    parameter int H_FRONTPORCH      = 40,
    parameter int H_SYNCTIME        = 128,
    parameter int H_BACKPORCH       = 88,
    parameter int V_LINES           = 600,
    parameter int V_FRONTPORCH      = 1,
    parameter int V_SYNCTIME        = 4,
    parameter int V_BACKPORCH       = 23,
    parameter bit H_SYNC_POL        = 1'b0,
    parameter bit V_SYNC_POL        = 1'b0,
    parameter int PIXEL_GEN_BITS    = 12,
    parameter int RED_W             = 5,
    parameter int GREEN_W           = 6,
    parameter int BLUE_W            = 5,
    parameter int NUMBER_OF_COLUMNS = 8,
    parameter int CHECK_LOG2        = 5,
    parameter int SCROLL_STEP       = 4
) (
    input  logic               clk_pll,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               freeze,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               DE,
    output logic               FRAME_START,
    output logic [RED_W-1:0]   RED_OUT,
    output logic [GREEN_W-1:0] GREEN_OUT,
    output logic [BLUE_W-1:0]  BLUE_OUT
);

    localparam int PGB   = PIXEL_GEN_BITS;
    localparam int XW    = PIXEL_GEN_BITS + 1;
    localparam int BAR_W = H_PIXELS / NUMBER_OF_COLUMNS;

    logic [PGB-1:0] h_s0, v_s0;
    logic           active_s0, hs_s0, vs_s0, fs_s0;

    vga_timing_gen #(
        .H_PIXELS      (H_PIXELS),
        .H_FRONTPORCH  (H_FRONTPORCH),
        .H_SYNCTIME    (H_SYNCTIME),
        .H_BACKPORCH   (H_BACKPORCH),
        .V_LINES       (V_LINES),
        .V_FRONTPORCH  (V_FRONTPORCH),
        .V_SYNCTIME    (V_SYNCTIME),
        .V_BACKPORCH   (V_BACKPORCH),
        .PIXEL_GEN_BITS(PIXEL_GEN_BITS)
    ) u_timing (
        .clk        (clk_pll),
        .rst_n      (rst),
        .h_cnt      (h_s0),
        .v_cnt      (v_s0),
        .active     (active_s0),
        .hsync_act  (hs_s0),
        .vsync_act  (vs_s0),
        .frame_start(fs_s0)
    );

    // Per-frame state: latched on the same edge that moves (0,0) into S1,
    // so the whole new frame sees a consistent mode and offset.
    vga_mode_e      mode_q, mode_d;
    logic [PGB-1:0] frame_cnt_q, frame_cnt_d;
    logic [PGB-1:0] offset_q, offset_d;
    logic [XW-1:0]  offset_sum;

    // S1 pipeline registers
    logic [PGB-1:0] x_p1_q, x_p1_d;
    logic [PGB-1:0] y_p1_q, y_p1_d;
    logic           de_p1_q, de_p1_d;
    logic           hs_p1_q, hs_p1_d;
    logic           vs_p1_q, vs_p1_d;
    logic           fs_p1_q, fs_p1_d;

    // S2 output registers
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic               fs_q, fs_d;
    logic [RED_W-1:0]   red_q, red_d;
    logic [GREEN_W-1:0] green_q, green_d;
    logic [BLUE_W-1:0]  blue_q, blue_d;

    logic [XW-1:0] scroll_sum;
    logic [XW-1:0] bar_x;
    logic [2:0]    col;
    logic [2:0]    ci;
    logic          chk_odd;

    // S0 -> S1: capture raster position and flags, update frame state
    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        offset_d    = offset_q;
        // Scroll offset tracks frame_cnt*SCROLL_STEP mod H_PIXELS incrementally.
        offset_sum  = {1'b0, offset_q} + XW'(SCROLL_STEP);
        if (fs_s0) begin
            mode_d = vga_mode_e'(mode);
            if (!freeze) begin
                frame_cnt_d = frame_cnt_q + PGB'(1);
                offset_d    = PGB'((offset_sum >= XW'(H_PIXELS)) ? offset_sum - XW'(H_PIXELS)
                                                                 : offset_sum);
            end
        end
        x_p1_d  = h_s0;
        y_p1_d  = v_s0;
        de_p1_d = active_s0;
        hs_p1_d = hs_s0;
        vs_p1_d = vs_s0;
        fs_p1_d = fs_s0;
    end

    // S1 -> S2: pattern generation, blanking and sync polarity
    always_comb begin
        scroll_sum = {1'b0, x_p1_q} + {1'b0, offset_q};
        bar_x      = {1'b0, x_p1_q};
        if (mode_q == MODE_SCROLL) begin
            bar_x = (scroll_sum >= XW'(H_PIXELS)) ? scroll_sum - XW'(H_PIXELS) : scroll_sum;
        end

        // Column by threshold compare; pixels past the last full bar stay in
        // the last column, and the 3-bit cast gives the mod-8 colour cycle.
        col = '0;
        for (int k = 1; k < NUMBER_OF_COLUMNS; k++) begin
            if (bar_x >= XW'(k * BAR_W)) begin
                col = 3'(k);
            end
        end

        chk_odd = |(((x_p1_q >> CHECK_LOG2) ^ (y_p1_q >> CHECK_LOG2)) & PGB'(1));

        ci = bar_colour(col);
        if (mode_q == MODE_CHECK) begin
            ci = chk_odd ? CI_BLACK : CI_WHITE;
        end

        red_d   = {RED_W{ci[2]}};
        green_d = {GREEN_W{ci[1]}};
        blue_d  = {BLUE_W{ci[0]}};
        if (mode_q == MODE_GRAD) begin
            red_d   = x_p1_q[RED_W-1:0];
            green_d = y_p1_q[GREEN_W-1:0];
            blue_d  = ~x_p1_q[BLUE_W-1:0];
        end
        if (!de_p1_q) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end

        hsync_d = hs_p1_q ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = vs_p1_q ? V_SYNC_POL : ~V_SYNC_POL;
        de_d    = de_p1_q;
        fs_d    = fs_p1_q;
    end

    always_ff @(posedge clk_pll or negedge rst) begin
        if (!rst) begin
            mode_q      <= MODE_BARS;
            frame_cnt_q <= '0;
            offset_q    <= '0;
            x_p1_q      <= '0;
            y_p1_q      <= '0;
            de_p1_q     <= 1'b0;
            hs_p1_q     <= 1'b0;
            vs_p1_q     <= 1'b0;
            fs_p1_q     <= 1'b0;
            hsync_q     <= ~H_SYNC_POL;
            vsync_q     <= ~V_SYNC_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            offset_q    <= offset_d;
            x_p1_q      <= x_p1_d;
            y_p1_q      <= y_p1_d;
            de_p1_q     <= de_p1_d;
            hs_p1_q     <= hs_p1_d;
            vs_p1_q     <= vs_p1_d;
            fs_p1_q     <= fs_p1_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DE          = de_q;
    assign FRAME_START = fs_q;
    assign RED_OUT     = red_q;
    assign GREEN_OUT   = green_q;
    assign BLUE_OUT    = blue_q;

endmodule
